// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: loads block^key, issues one token per round,
// times each round capture, and presents the ciphertext through a valid/ready hold.
module aes_round_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       out_ready,
    output logic       busy,
    output logic       load_sel,
    output logic       round_en,
    output logic       empty,
    output logic       last_round,
    output logic [7:0] Rcon_out,
    output logic [3:0] round_cnt,
    output logic       out_valid,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [3:0] NR_C     = 4'(NR);
    localparam logic [3:0] LAT_INIT = 4'(ROUND_LAT - 1);
    localparam logic [7:0] RCON_1   = 8'h01;

    // Handshake: out_valid is high for every HOLD cycle; the ciphertext is
    // accepted on the rising edge where out_valid and out_ready are both high,
    // and out_valid drops in the following cycle.

    logic [2:0] state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q,  rcon_d;
    logic [3:0] lat_q,   lat_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            rcon_q  <= RCON_1;
            lat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    round_d = 4'd0;
                    rcon_d  = RCON_1;
                end
            end
            S_LOAD: begin
                state_d = S_ISSUE;
                round_d = round_q + 4'd1;
            end
            S_ISSUE: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == 4'd0) begin
                    if (round_q == NR_C) begin
                        state_d = S_HOLD;
                    end else begin
                        // Round counter and Rcon change together as the next token issues.
                        state_d = S_ISSUE;
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                    rcon_d  = RCON_1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state; inputs only steer next state.
    assign busy       = (state_q != S_IDLE);
    assign load_sel   = (state_q == S_LOAD);
    assign round_en   = (state_q == S_LOAD) || ((state_q == S_WAIT) && (lat_q == 4'd0));
    assign empty      = (state_q != S_ISSUE);
    assign last_round = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (round_q == NR_C);
    assign Rcon_out   = rcon_q;
    assign round_cnt  = round_q;
    assign out_valid  = (state_q == S_HOLD);
    assign dbg_state  = state_q;

endmodule
